// File: rtl/ccff_chain_loader.sv
// Bitstream loader for a serial configuration flip-flop chain.
// It accepts bytes, shifts them MSB-first into the chain head and tracks tail parity.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN    = 40,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned UNDERRUN_MAX = 1024
) (
    input  logic       prog_clk,
    input  logic       prog_rst_n,
    input  logic       start,
    input  logic       bs_valid,
    input  logic [7:0] bs_data,
    output logic       bs_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       tail_parity
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PEND_W = 4;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(UNDERRUN_MAX - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(BYTE_W);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [BYTE_W-1:0] byte_buf;
    logic [PEND_W-1:0] pend;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  to_cnt;

    logic in_load;
    logic have_bits;

    // Handshake and chain strobes are pure decodes of registered state.
    assign in_load       = (state == S_LOAD);
    assign have_bits     = (pend != '0);
    assign bs_ready      = in_load && !have_bits;
    assign ccff_shift_en = in_load && have_bits;
    assign ccff_head     = ccff_shift_en && byte_buf[BYTE_W-1];
    assign busy          = in_load;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state       <= S_IDLE;
            byte_buf    <= '0;
            pend        <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            tail_parity <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (have_bits) begin
                        byte_buf    <= {byte_buf[BYTE_W-2:0], 1'b0};
                        pend        <= pend - PEND_ONE;
                        bit_cnt     <= bit_cnt + CNT_ONE;
                        tail_parity <= tail_parity ^ ccff_tail;
                        // Last chain bit: drop whatever is left of the final byte.
                        if (bit_cnt == LAST_BIT) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            pend     <= '0;
                            byte_buf <= '0;
                        end
                    end else if (bs_valid) begin
                        byte_buf <= bs_data;
                        pend     <= PEND_FULL;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + CNT_ONE;
                        if (to_cnt == TO_LAST) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all restart the same way.
                    if (start) begin
                        state       <= S_LOAD;
                        byte_buf    <= '0;
                        pend        <= '0;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        tail_parity <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized self-checking bench for ccff_chain_loader with a chain model on the tail.
// A second instance with a 12-bit chain covers partial-final-byte discard.
module tb_ccff_chain_loader;

    localparam int unsigned CL     = 40;
    localparam int unsigned CL_S   = 12;
    localparam int unsigned UR     = 16;
    localparam int          BUDGET = 600;

    typedef logic [7:0] byte_q_t[$];
    typedef logic       bit_q_t[$];

    logic       prog_clk   = 1'b0;
    logic       prog_rst_n = 1'b0;
    logic       start      = 1'b0;
    logic       bs_valid   = 1'b0;
    logic [7:0] bs_data    = 8'h00;
    logic       bs_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic       busy, done, error, tail_parity;

    logic       s_start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_tail  = 1'b0;
    logic       s_ready, s_head, s_shift_en, s_busy, s_done, s_error, s_parity;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .CNT_W(16), .UNDERRUN_MAX(UR)) dut (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error), .tail_parity(tail_parity)
    );

    ccff_chain_loader #(.CHAIN_LEN(CL_S), .CNT_W(16), .UNDERRUN_MAX(1024)) dut_s (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(s_start),
        .bs_valid(s_valid), .bs_data(s_data), .bs_ready(s_ready),
        .ccff_head(s_head), .ccff_shift_en(s_shift_en), .ccff_tail(s_tail),
        .busy(s_busy), .done(s_done), .error(s_error), .tail_parity(s_parity)
    );

    // Behavioural model of the downstream 40-bit configuration chain.
    logic [CL-1:0] chain        = '0;
    logic [CL-1:0] chain_preset = '0;
    logic          chain_load   = 1'b0;
    always @(posedge prog_clk) begin
        if (chain_load)         chain <= chain_preset;
        else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1];

    int n_checks = 0;
    int n_pass   = 0;

    int            n_shift, n_bubble, n_starve;
    logic          finished, restart_fired;
    logic          par_first, done_first, err_first;
    bit_q_t        heads;
    logic [CL-1:0] chain_at_start;

    function automatic bit_q_t exp_bits(input byte_q_t b, input int n);
        bit_q_t     q;
        logic [7:0] v;
        for (int i = 0; i < int'(b.size()); i++) begin
            v = b[i];
            for (int j = 7; j >= 0; j--) if (int'(q.size()) < n) q.push_back(v[j]);
        end
        return q;
    endfunction

    function automatic int bit_diff(input bit_q_t a, input bit_q_t e);
        int d;
        d = (a.size() != e.size()) ? 1 : 0;
        for (int i = 0; i < int'(a.size()) && i < int'(e.size()); i++)
            if (a[i] !== e[i]) d++;
        return d;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic preload(input logic [CL-1:0] v);
        @(negedge prog_clk);
        chain_preset = v;
        chain_load   = 1'b1;
        @(negedge prog_clk);
        chain_load   = 1'b0;
    endtask

    // Start a load, feed bytes with random gaps and record every cycle until LOAD is left.
    task automatic run_load(input byte_q_t bytes, input int max_gap,
                            input int restart_at, input int stop_at);
        int   idx, gap;
        logic acc;
        idx = 0; gap = 0; acc = 1'b0;
        n_shift = 0; n_bubble = 0; n_starve = 0;
        heads.delete();
        finished = 1'b0; restart_fired = 1'b0;
        chain_at_start = chain;
        @(negedge prog_clk);
        start = 1'b1; bs_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (acc) begin
                idx++;
                gap = int'($urandom_range(max_gap, 0));
            end
            if (stop_at >= 0 && n_shift == stop_at) begin
                bs_valid = 1'b0;
                return;
            end
            if (c == 0) begin
                par_first  = tail_parity;
                done_first = done;
                err_first  = error;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (restart_at >= 0 && n_shift == restart_at && !restart_fired) begin
                start = 1'b1;
                restart_fired = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (gap > 0) begin
                bs_valid = 1'b0;
                gap--;
            end else if (idx < int'(bytes.size())) begin
                bs_valid = 1'b1;
                bs_data  = bytes[idx];
            end else begin
                bs_valid = 1'b0;
            end
            acc = bs_valid && bs_ready;
            if (ccff_shift_en) begin
                heads.push_back(ccff_head);
                n_shift++;
            end else if (bs_ready && n_shift > 0) begin
                n_bubble++;
            end
            if (bs_ready && !bs_valid) n_starve++;
            @(negedge prog_clk);
        end
        start = 1'b0;
        bs_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        prog_rst_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        n_checks++;
        if ({bs_ready, ccff_head, ccff_shift_en, busy} !== 4'b0)
            $display("FAIL reset_strobes: got %b expected 0000", {bs_ready, ccff_head, ccff_shift_en, busy});
        else n_pass++;
        n_checks++;
        if ({done, error, tail_parity, s_busy, s_done} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {done, error, tail_parity, s_busy, s_done});
        else n_pass++;
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        bs_valid = 1'b1; bs_data = 8'hFF;
        bad = 1'b0;
        repeat (6) begin
            @(negedge prog_clk);
            if (bs_ready || ccff_shift_en || busy) bad = 1'b1;
        end
        bs_valid = 1'b0;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL idle_after_reset: activity=%b expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_short_chain();
        byte_q_t b;
        bit_q_t  got, e;
        int      idx;
        logic    acc, bad;
        b = '{8'hF0, 8'hAB};
        e = exp_bits(b, CL_S);
        idx = 0; acc = 1'b0;
        @(negedge prog_clk); s_start = 1'b1;
        @(negedge prog_clk); s_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (acc) idx++;
            if (!s_busy) break;
            s_valid = (idx < 2);
            s_data  = (idx < 2) ? b[idx] : 8'h00;
            acc = s_valid && s_ready;
            if (s_shift_en) got.push_back(s_head);
            @(negedge prog_clk);
        end
        n_checks++;
        if (got.size() != CL_S) $display("FAIL short_shift_count: got %0d expected %0d", got.size(), CL_S);
        else n_pass++;
        n_checks++;
        if (bit_diff(got, e) != 0) $display("FAIL short_head_bits: got %0d bit errors expected 0", bit_diff(got, e));
        else n_pass++;
        n_checks++;
        if ({s_done, s_busy, s_error, s_parity} !== 4'b1000)
            $display("FAIL short_done_flags: got %b expected 1000", {s_done, s_busy, s_error, s_parity});
        else n_pass++;
        s_valid = 1'b1; s_data = 8'hFF;
        bad = 1'b0;
        repeat (4) begin
            @(negedge prog_clk);
            if (s_ready || s_shift_en || !s_done) bad = 1'b1;
        end
        s_valid = 1'b0;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL short_discard: activity=%b expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_fixed_pattern();
        byte_q_t b;
        b = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        preload(40'h01_0000_0003);
        run_load(b, 0, -1, -1);
        n_checks++;
        if (finished !== 1'b1) $display("FAIL fixed_finished: got %b expected 1", finished);
        else n_pass++;
        n_checks++;
        if (n_shift != 40) $display("FAIL fixed_shift_count: got %0d expected 40", n_shift);
        else n_pass++;
        n_checks++;
        if (bit_diff(heads, exp_bits(b, CL)) != 0)
            $display("FAIL fixed_head_bits: got %0d bit errors expected 0", bit_diff(heads, exp_bits(b, CL)));
        else n_pass++;
        n_checks++;
        if (n_bubble != 4) $display("FAIL fixed_bubbles: got %0d expected 4", n_bubble);
        else n_pass++;
        n_checks++;
        if ({done, busy, error} !== 3'b100) $display("FAIL fixed_flags: got %b expected 100", {done, busy, error});
        else n_pass++;
        n_checks++;
        if (tail_parity !== 1'b1) $display("FAIL fixed_tail_parity: got %b expected 1", tail_parity);
        else n_pass++;
    endtask

    task automatic test_parity_reclear();
        byte_q_t b;
        b = rand_bytes(5);
        run_load(b, 2, -1, -1);
        n_checks++;
        if ({par_first, done_first} !== 2'b00)
            $display("FAIL reclear_on_start: got %b expected 00", {par_first, done_first});
        else n_pass++;
        n_checks++;
        if (tail_parity !== ^chain_at_start)
            $display("FAIL reclear_parity: got %b expected %b", tail_parity, ^chain_at_start);
        else n_pass++;
    endtask

    task automatic test_random_loads();
        byte_q_t b;
        for (int it = 0; it < 5; it++) begin
            b = rand_bytes(5 + int'($urandom_range(1, 0)));
            run_load(b, 3, -1, -1);
            n_checks++;
            if (finished !== 1'b1 || n_shift != 40)
                $display("FAIL rand_shift_count[%0d]: got %0d finished=%b expected 40", it, n_shift, finished);
            else n_pass++;
            n_checks++;
            if (bit_diff(heads, exp_bits(b, CL)) != 0)
                $display("FAIL rand_head_bits[%0d]: got %0d bit errors expected 0", it, bit_diff(heads, exp_bits(b, CL)));
            else n_pass++;
            n_checks++;
            if ({done, error, tail_parity} !== {2'b10, ^chain_at_start})
                $display("FAIL rand_flags[%0d]: got %b expected %b", it, {done, error, tail_parity}, {2'b10, ^chain_at_start});
            else n_pass++;
        end
    endtask

    task automatic test_underrun();
        byte_q_t b;
        b = '{8'h5A};
        run_load(b, 0, -1, -1);
        n_checks++;
        if (finished !== 1'b1 || n_shift != 8)
            $display("FAIL underrun_shifts: got %0d finished=%b expected 8", n_shift, finished);
        else n_pass++;
        n_checks++;
        if (n_starve != int'(UR)) $display("FAIL underrun_starved: got %0d expected %0d", n_starve, UR);
        else n_pass++;
        n_checks++;
        if ({error, done, busy, ccff_shift_en, bs_ready} !== 5'b10000)
            $display("FAIL underrun_flags: got %b expected 10000", {error, done, busy, ccff_shift_en, bs_ready});
        else n_pass++;
        n_checks++;
        if (bit_diff(heads, exp_bits(b, 8)) != 0)
            $display("FAIL underrun_head_bits: got %0d bit errors expected 0", bit_diff(heads, exp_bits(b, 8)));
        else n_pass++;
        b = rand_bytes(5);
        run_load(b, 1, -1, -1);
        n_checks++;
        if ({err_first, par_first} !== 2'b00) $display("FAIL err_clear_on_start: got %b expected 00", {err_first, par_first});
        else n_pass++;
        n_checks++;
        if ({done, error} !== 2'b10 || n_shift != 40)
            $display("FAIL err_restart: got done/error %b shifts %0d expected 10 and 40", {done, error}, n_shift);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        byte_q_t b;
        b = rand_bytes(5);
        run_load(b, 0, 20, -1);
        n_checks++;
        if (restart_fired !== 1'b1 || n_shift != 40)
            $display("FAIL start_ignored_shifts: got %0d fired=%b expected 40", n_shift, restart_fired);
        else n_pass++;
        n_checks++;
        if (bit_diff(heads, exp_bits(b, CL)) != 0 || done !== 1'b1)
            $display("FAIL start_ignored_bits: got %0d bit errors done=%b expected 0 and 1", bit_diff(heads, exp_bits(b, CL)), done);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        byte_q_t b;
        logic    bad;
        b = rand_bytes(5);
        run_load(b, 0, -1, 17);
        n_checks++;
        if (busy !== 1'b1 || n_shift != 17) $display("FAIL midload_reached: got busy=%b shifts=%0d expected 1 and 17", busy, n_shift);
        else n_pass++;
        #2 prog_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bs_ready, ccff_head, ccff_shift_en, busy, done, error, tail_parity} !== 7'b0)
            $display("FAIL midload_async_reset: got %b expected 0000000",
                     {bs_ready, ccff_head, ccff_shift_en, busy, done, error, tail_parity});
        else n_pass++;
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        bs_valid = 1'b1; bs_data = 8'hC3;
        bad = 1'b0;
        repeat (6) begin
            @(negedge prog_clk);
            if (bs_ready || ccff_shift_en || busy) bad = 1'b1;
        end
        bs_valid = 1'b0;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL midload_stays_idle: activity=%b expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_chain();
        test_fixed_pattern();
        test_parity_reclear();
        test_random_loads();
        test_underrun();
        test_start_ignored();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 40, meaning number of configuration flip-flops in the downstream ccff chain (1..65535).
REQ-002 Parameter CNT_W, default 16, meaning width of the bit and timeout counters; SHALL satisfy 2^CNT_W > max(CHAIN_LEN, UNDERRUN_MAX).
REQ-003 Parameter UNDERRUN_MAX, default 1024, meaning consecutive starved LOAD cycles tolerated before error.
REQ-004 prog_clk  input  1  configuration clock; all state on rising edge.
REQ-005 prog_rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 bs_valid  input  1  bitstream byte available.
REQ-008 bs_data  input  8  bitstream byte, MSB shifted first.
REQ-009 bs_ready  output  1  loader accepts bs_data this cycle.
REQ-010 ccff_head  output  1  serial configuration bit into chain head.
REQ-011 ccff_shift_en  output  1  chain clock-enable; the chain captures ccff_head on the prog_clk edge ending a cycle in which this is high.
REQ-012 ccff_tail  input  1  serial bit leaving the last chain flip-flop.
REQ-013 busy  output  1  high in LOAD.
REQ-014 done  output  1  sticky; load completed.
REQ-015 error  output  1  sticky; underrun timeout.
REQ-016 tail_parity  output  1  XOR of all ccff_tail bits sampled during shifting of the current or last load.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE, ERR.
REQ-018 IDLE/DONE/ERR -> LOAD when start=1; on that edge bit counter, byte buffer, timeout counter, tail_parity clear, and done/error clear.
REQ-019 start while in LOAD SHALL be ignored.
REQ-020 In LOAD, bs_ready SHALL be 1 exactly when the byte buffer is empty; a byte is accepted on bs_valid&&bs_ready and loaded with 8 bits pending.
REQ-021 ccff_shift_en SHALL be 1 exactly when state is LOAD and the buffer holds at least one pending bit; ccff_head SHALL equal the buffer's current MSB in that cycle, else 0.
REQ-022 Each shift cycle SHALL decrement pending bits, advance the buffer MSB-first, and increment the chain bit counter; an emptied buffer requires one cycle of bs_ready before the next shift (one-cycle bubble per byte).
REQ-023 Each shift cycle SHALL update tail_parity <= tail_parity ^ ccff_tail.
REQ-024 When the shift cycle delivering bit CHAIN_LEN occurs, state -> DONE on that edge; remaining bits of the final byte SHALL be discarded; done <= 1.
REQ-025 Exactly CHAIN_LEN cycles with ccff_shift_en=1 SHALL occur per successful load.
REQ-026 Timeout counter SHALL increment each LOAD cycle with bs_ready=1 and bs_valid=0, clear on any byte acceptance; reaching UNDERRUN_MAX SHALL move state to ERR, set error, deassert ccff_shift_en and bs_ready.
REQ-027 In IDLE, DONE, ERR: bs_ready=0, ccff_shift_en=0, ccff_head=0.
REQ-028 start and byte acceptance never coincide (bs_ready is 0 outside LOAD); a start on the same edge as completion is not possible since start is ignored in LOAD.

Reset
REQ-029 prog_rst_n=0 SHALL immediately force IDLE, bs_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, tail_parity=0, all counters and buffer 0, regardless of state, including mid-load.
REQ-030 After reset deassertion no shifting SHALL occur until start.

Verification
REQ-031 CHAIN_LEN=40, start, 5 bytes 0xA5,0x3C,0xFF,0x00,0x81 always valid -> exactly 40 shift_en cycles, head sequence equals bytes MSB-first, 4 bubbles, done=1, busy=0.
REQ-032 CHAIN_LEN=12, bytes 0xF0,0xAB -> 12 shifts (11110000 1010), low nibble 0xB discarded, done=1.
REQ-033 bs_valid held 0 after first byte, UNDERRUN_MAX=16 -> 8 shifts, then error=1 after 16 starved cycles, shift_en=0, ERR state; new start clears error and restarts.
REQ-034 ccff_tail driven with model of 40-bit chain preloaded 0x01_0000_0003 -> tail_parity=1 at done; next load re-clears parity.
REQ-035 prog_rst_n pulsed low after 17 shifts -> all outputs zero asynchronously, IDLE; bs_ready stays 0 until start.
REQ-036 start asserted during LOAD at shift 20 -> ignored, load completes with 40 shifts, done=1.
